wb_cmd_master: RTL and testbench

Wishbone classic-cycle initiator that turns a simple valid/ready command stream into single read or write bus cycles toward the peripheral slaves (gpio, gpi, gpo and similar) on the shared slave bus. It sits between a control source and the bus fabric: a test sequencer, debug bridge or small controller. It provides:
- a registered bus interface,
- a bounded wait for termination, with timeout,
- limited automatic retry on `rty`,
- a held response carrying read data and a completion status.

---
 rtl/wb_cmd_master_if.sv | 44 ++++
 rtl/wb_cmd_master.sv | 131 +++++++++++++
 tb/tb_wb_cmd_master.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_cmd_master_if.sv
// Command/response stream plus Wishbone classic master signals
// for wb_cmd_master; master = the initiator, slave = its environment.
interface wb_cmd_master_if #(
    parameter int Dw   = 32,
    parameter int Aw   = 2,
    parameter int SELw = 4,
    parameter int TAGw = 3
);
    logic            cmd_valid_i;
    logic            cmd_ready_o;
    logic            cmd_we_i;
    logic [Aw-1:0]   cmd_addr_i;
    logic [Dw-1:0]   cmd_dat_i;
    logic [SELw-1:0] cmd_sel_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [Dw-1:0]   rsp_dat_o;
    logic [1:0]      rsp_status_o;
    logic [Aw-1:0]   m_addr_o;
    logic [Dw-1:0]   m_dat_o;
    logic [SELw-1:0] m_sel_o;
    logic [TAGw-1:0] m_tag_o;
    logic            m_we_o;
    logic            m_stb_o;
    logic            m_cyc_o;
    logic [Dw-1:0]   m_dat_i;
    logic            m_ack_i;
    logic            m_err_i;
    logic            m_rty_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_dat_i, cmd_sel_i,
        input  rsp_ready_i, m_dat_i, m_ack_i, m_err_i, m_rty_i,
        output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_status_o,
        output m_addr_o, m_dat_o, m_sel_o, m_tag_o, m_we_o, m_stb_o, m_cyc_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_dat_i, cmd_sel_i,
        output rsp_ready_i, m_dat_i, m_ack_i, m_err_i, m_rty_i,
        input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_status_o,
        input  m_addr_o, m_dat_o, m_sel_o, m_tag_o, m_we_o, m_stb_o, m_cyc_o
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-cycle initiator driven by a valid/ready
// command stream, with per-attempt timeout and bounded retry on rty.
module wb_cmd_master #(
    parameter int Dw        = 32,
    parameter int Aw        = 2,
    parameter int SELw      = 4,
    parameter int TAGw      = 3,
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 3
) (
    input logic clk,
    input logic reset,
    wb_cmd_master_if.master bus
);
    localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUS, GAP, RESP} state_t;

    state_t          state, state_d;
    logic [15:0]     tmo, tmo_d;
    logic [RW-1:0]   rcnt, rcnt_d;
    logic            we_q, we_d;
    logic [Aw-1:0]   addr_q, addr_d;
    logic [Dw-1:0]   dat_q, dat_d;
    logic [SELw-1:0] sel_q, sel_d;
    logic [Dw-1:0]   rdat_q, rdat_d;
    logic [1:0]      status_q, status_d;
    logic            stb_q;
    logic            rvalid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tmo      <= '0;
            rcnt     <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            rdat_q   <= '0;
            status_q <= 2'b00;
            stb_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state    <= state_d;
            tmo      <= tmo_d;
            rcnt     <= rcnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            rdat_q   <= rdat_d;
            status_q <= status_d;
            // strobe and response flag are flops of the next state
            stb_q    <= (state_d == BUS);
            rvalid_q <= (state_d == RESP);
        end
    end

    always_comb begin
        state_d  = state;
        tmo_d    = tmo;
        rcnt_d   = rcnt;
        we_d     = we_q;
        addr_d   = addr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        rdat_d   = rdat_q;
        status_d = status_q;
        unique case (state)
            IDLE: begin
                if (bus.cmd_valid_i) begin
                    we_d    = bus.cmd_we_i;
                    addr_d  = bus.cmd_addr_i;
                    dat_d   = bus.cmd_dat_i;
                    sel_d   = bus.cmd_sel_i;
                    rcnt_d  = '0;
                    tmo_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (bus.m_err_i) begin
                    status_d = 2'b01;
                    rdat_d   = '0;
                    state_d  = RESP;
                end else if (bus.m_ack_i) begin
                    status_d = 2'b00;
                    rdat_d   = we_q ? '0 : bus.m_dat_i;
                    state_d  = RESP;
                end else if (bus.m_rty_i) begin
                    if (int'(rcnt) < MAX_RETRY) begin
                        rcnt_d  = rcnt + RW'(1);
                        state_d = GAP;
                    end else begin
                        status_d = 2'b11;
                        rdat_d   = '0;
                        state_d  = RESP;
                    end
                end else if (tmo == TMO_LAST) begin
                    status_d = 2'b10;
                    rdat_d   = '0;
                    state_d  = RESP;
                end else begin
                    tmo_d = tmo + 16'd1;
                end
            end
            GAP: begin
                tmo_d   = '0;
                state_d = BUS;
            end
            RESP: begin
                if (bus.rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready_o  = (state == IDLE);
    assign bus.rsp_valid_o  = rvalid_q;
    assign bus.rsp_dat_o    = rdat_q;
    assign bus.rsp_status_o = status_q;
    assign bus.m_addr_o     = addr_q;
    assign bus.m_dat_o      = dat_q;
    assign bus.m_sel_o      = sel_q;
    assign bus.m_tag_o      = '0;
    assign bus.m_we_o       = we_q;
    assign bus.m_stb_o      = stb_q;
    assign bus.m_cyc_o      = stb_q;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomized bench for wb_cmd_master: scripted slave plus a
// per-transaction outcome model and a per-cycle bus monitor.
module tb_wb_cmd_master;
    localparam int Dw = 32, Aw = 2, SELw = 4, TAGw = 3;
    localparam int T = 8, MR = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;

    wb_cmd_master_if #(.Dw(Dw), .Aw(Aw), .SELw(SELw), .TAGw(TAGw)) bus ();

    wb_cmd_master #(
        .Dw(Dw), .Aw(Aw), .SELw(SELw), .TAGw(TAGw),
        .TIMEOUT(T), .MAX_RETRY(MR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // per-attempt slave script: 0 ack, 1 err, 2 rty, 3 silent, 4 err+ack
    int          kind[MR+1];
    int          dly[MR+1];
    logic [31:0] rd[MR+1];
    int          att;
    int          cnt;
    bit          sprev;
    logic [31:0] gpo;

    logic            exp_we;
    logic [Aw-1:0]   exp_addr;
    logic [Dw-1:0]   exp_dat;
    logic [SELw-1:0] exp_sel;

    always @(negedge clk) begin
        bus.m_ack_i = 1'b0;
        bus.m_err_i = 1'b0;
        bus.m_rty_i = 1'b0;
        bus.m_dat_i = $urandom;
        if (bus.m_stb_o) begin
            if (!sprev) begin
                att++;
                cnt = 0;
            end else begin
                cnt++;
            end
            if (att >= 0 && att <= MR && cnt == dly[att]) begin
                case (kind[att])
                    0: begin
                        bus.m_ack_i = 1'b1;
                        bus.m_dat_i = rd[att];
                        if (bus.m_we_o) gpo = bus.m_dat_o;
                    end
                    1: bus.m_err_i = 1'b1;
                    2: bus.m_rty_i = 1'b1;
                    4: begin
                        bus.m_err_i = 1'b1;
                        bus.m_ack_i = 1'b1;
                    end
                    default: ;
                endcase
            end
        end else if (!reset) begin
            bus.m_ack_i = ($urandom_range(3) == 0);
            bus.m_err_i = ($urandom_range(3) == 0);
            bus.m_rty_i = ($urandom_range(3) == 0);
        end
        sprev = bus.m_stb_o;
    end

    int run_q[$];
    int gap_q[$];
    int run_len = 0;
    int low_len = 0;
    bit mprev = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            mprev   = 1'b0;
            run_len = 0;
            low_len = 0;
        end else begin
            check("cyc_eq_stb", bus.m_cyc_o, bus.m_stb_o);
            check("tag_zero", bus.m_tag_o, 0);
            if (bus.m_stb_o) begin
                check("bus_addr", bus.m_addr_o, exp_addr);
                check("bus_dat", bus.m_dat_o, exp_dat);
                check("bus_sel", bus.m_sel_o, exp_sel);
                check("bus_we", bus.m_we_o, exp_we);
                check("no_rsp_in_bus", bus.rsp_valid_o, 0);
                if (!mprev) begin
                    if (run_q.size() > 0) gap_q.push_back(low_len);
                    run_len = 1;
                end else begin
                    run_len++;
                end
            end else begin
                if (mprev) run_q.push_back(run_len);
                low_len = mprev ? 1 : low_len + 1;
            end
            mprev = bus.m_stb_o;
        end
    end

    task automatic set_plan(input int k0, input int k1, input int k2,
                            input int d0, input int d1, input int d2);
        kind[0] = k0; kind[1] = k1; kind[2] = k2;
        dly[0] = d0; dly[1] = d1; dly[2] = d2;
        for (int i = 0; i <= MR; i++) rd[i] = $urandom;
    endtask

    // outcome of one command from the script alone
    task automatic model(input bit we, output int st, output logic [31:0] dat,
                         output int lat, output int nruns, output int runs[MR+1]);
        st = 0;
        dat = '0;
        nruns = 0;
        lat = 0;
        for (int i = 0; i <= MR; i++) runs[i] = 0;
        for (int i = 0; i <= MR; i++) begin
            nruns = i + 1;
            if (kind[i] == 3 || dly[i] >= T) begin
                runs[i] = T;
                st = 2;
                break;
            end
            runs[i] = dly[i] + 1;
            if (kind[i] == 1 || kind[i] == 4) begin
                st = 1;
                break;
            end
            if (kind[i] == 0) begin
                st = 0;
                dat = we ? 32'd0 : rd[i];
                break;
            end
            if (i == MR) st = 3;
        end
        for (int i = 0; i < nruns; i++) lat += runs[i];
        lat += nruns - 1;
    endtask

    task automatic run_cmd(input bit we, input logic [Aw-1:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int lit_st, input int lit_lat,
                           input int lit_dat, input int hold);
        int st, lat_m, nruns, lat;
        int runs[MR+1];
        logic [31:0] dat_m;
        model(we, st, dat_m, lat_m, nruns, runs);
        check("cmd_ready_idle", bus.cmd_ready_o, 1);
        att = -1;
        run_q.delete();
        gap_q.delete();
        exp_we = we;
        exp_addr = a;
        exp_dat = d;
        exp_sel = s;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i = we;
        bus.cmd_addr_i = a;
        bus.cmd_dat_i = d;
        bus.cmd_sel_i = s;
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i = ~we;
        bus.cmd_addr_i = ~a;
        bus.cmd_dat_i = $urandom;
        bus.cmd_sel_i = ~s;
        lat = 0;
        while (!bus.rsp_valid_o && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 200) begin
            check("rsp_arrives", 0, 1);
            return;
        end
        check("latency", lat, lat_m);
        check("status", bus.rsp_status_o, st);
        check("rsp_dat", bus.rsp_dat_o, dat_m);
        if (lit_st >= 0) check("lit_status", bus.rsp_status_o, lit_st);
        if (lit_lat >= 0) check("lit_latency", lat, lit_lat);
        if (lit_dat >= 0) check("lit_rsp_dat", bus.rsp_dat_o, lit_dat);
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_valid", bus.rsp_valid_o, 1);
            check("hold_status", bus.rsp_status_o, st);
            check("hold_dat", bus.rsp_dat_o, dat_m);
            check("hold_not_ready", bus.cmd_ready_o, 0);
        end
        bus.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready_i = 1'b0;
        check("rsp_cleared", bus.rsp_valid_o, 0);
        check("ready_again", bus.cmd_ready_o, 1);
        check("attempts", run_q.size(), nruns);
        for (int i = 0; i < nruns && i < run_q.size(); i++)
            check("stb_run_len", run_q[i], runs[i]);
        check("gap_count", gap_q.size(), nruns - 1);
        foreach (gap_q[i]) check("gap_len", gap_q[i], 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i = 1'b0;
        bus.cmd_addr_i = '0;
        bus.cmd_dat_i = '0;
        bus.cmd_sel_i = '0;
        bus.rsp_ready_i = 1'b0;
        bus.m_ack_i = 1'b0;
        bus.m_err_i = 1'b0;
        bus.m_rty_i = 1'b0;
        bus.m_dat_i = '0;
        att = -1;
        cnt = 0;
        sprev = 1'b0;
        gpo = '0;
        set_plan(3, 3, 3, 0, 0, 0);
        #2;
        check("rst_cyc", bus.m_cyc_o, 0);
        check("rst_stb", bus.m_stb_o, 0);
        check("rst_we", bus.m_we_o, 0);
        check("rst_addr", bus.m_addr_o, 0);
        check("rst_dat", bus.m_dat_o, 0);
        check("rst_sel", bus.m_sel_o, 0);
        check("rst_rsp_valid", bus.rsp_valid_o, 0);
        check("rst_rsp_dat", bus.rsp_dat_o, 0);
        check("rst_status", bus.rsp_status_o, 0);
        check("rst_cmd_ready", bus.cmd_ready_o, 1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        set_plan(0, 0, 0, 1, 0, 0);
        run_cmd(1'b1, 2'd1, 32'h5A, 4'hF, 0, 2, 0, 0);
        check("gpo_port", gpo, 32'h5A);
        set_plan(0, 0, 0, 1, 0, 0);
        rd[0] = 32'h3;
        run_cmd(1'b0, 2'd0, 32'h0, 4'hF, 0, 2, 3, 5);
        set_plan(3, 3, 3, 0, 0, 0);
        run_cmd(1'b0, 2'd2, 32'h1234, 4'h3, 2, 8, 0, 1);
        set_plan(2, 2, 0, 0, 0, 0);
        run_cmd(1'b1, 2'd3, 32'hCAFE, 4'h1, 0, 5, 0, 0);
        set_plan(2, 2, 2, 0, 0, 0);
        run_cmd(1'b0, 2'd1, 32'h0, 4'hF, 3, 5, 0, 2);
        set_plan(4, 0, 0, 0, 0, 0);
        run_cmd(1'b0, 2'd2, 32'h0, 4'hF, 1, 1, 0, 0);
        set_plan(1, 0, 0, 2, 0, 0);
        run_cmd(1'b1, 2'd0, 32'h77, 4'h2, 1, 3, 0, 0);

        for (int n = 0; n < 150; n++) begin
            for (int i = 0; i <= MR; i++) begin
                int r;
                r = $urandom_range(9);
                kind[i] = (r < 4) ? 0 : (r == 4) ? 1 : (r < 8) ? 2 : (r == 8) ? 3 : 4;
                dly[i] = $urandom_range(9);
                rd[i] = $urandom;
            end
            run_cmd(1'($urandom), Aw'($urandom), $urandom, SELw'($urandom),
                    -1, -1, -1, $urandom_range(3));
        end

        set_plan(3, 3, 3, 0, 0, 0);
        att = -1;
        exp_we = 1'b1;
        exp_addr = 2'd2;
        exp_dat = 32'hDEAD;
        exp_sel = 4'hF;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i = 1'b1;
        bus.cmd_addr_i = 2'd2;
        bus.cmd_dat_i = 32'hDEAD;
        bus.cmd_sel_i = 4'hF;
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_reset_stb", bus.m_stb_o, 1);
        #3 reset = 1'b1;
        #1;
        check("async_cyc", bus.m_cyc_o, 0);
        check("async_stb", bus.m_stb_o, 0);
        check("async_rsp", bus.rsp_valid_o, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_rst_no_rsp", bus.rsp_valid_o, 0);
            check("post_rst_idle", bus.m_stb_o, 0);
        end
        set_plan(0, 0, 0, 1, 0, 0);
        rd[0] = 32'hA5A5_0001;
        run_cmd(1'b0, 2'd3, 32'h0, 4'hF, 0, 2, 32'hA5A5_0001, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
